iq_capture_ram: RTL and testbench

Snapshot buffer downstream of the NCO mixer stage. It captures a fixed-length burst of mixed complex samples (signed 8-bit real/imag, qualified by valid) into an on-chip RAM once armed. After the burst, it streams the samples back out in capture order over a valid/ready interface for inspection or further processing. It is used for debugging and characterising the mixer output without disturbing the live datapath.

---
 rtl/iq_capture_ram.sv | 163 ++++++++++++++++
 tb/tb_iq_capture_ram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iq_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : iq_capture_ram
// Description : Armed snapshot of DEPTH complex mixer samples into block RAM,
//               streamed back in capture order over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
module iq_capture_ram #(
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arm_i,
    input  logic [7:0] real_i,
    input  logic [7:0] imag_i,
    input  logic       valid_i,
    input  logic       rd_start_i,
    input  logic       rd_ready_i,
    output logic [7:0] real_o,
    output logic [7:0] imag_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int                c_DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = ADDR_W'(c_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_ONE       = ADDR_W'(1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_CAPTURE = 2'd1;
    localparam logic [1:0] c_ST_FULL    = 2'd2;
    localparam logic [1:0] c_ST_READ    = 2'd3;

    logic [15:0]       r_mem [c_DEPTH];
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_xfer_idx;
    logic              r_rd_all;
    logic [15:0]       r_ram_q;
    logic              r_q_vld;

    logic              w_wr_en;
    logic              w_rd_start;
    logic              w_out_adv;
    logic              w_xfer;
    logic              w_last_xfer;
    logic              w_rd_issue;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_wr_en     = (r_state == c_ST_CAPTURE) && valid_i;
    assign w_rd_start  = (r_state == c_ST_FULL) && rd_start_i;
    assign w_out_adv   = !valid_o || rd_ready_i;
    assign w_xfer      = valid_o && rd_ready_i;
    assign w_last_xfer = w_xfer && (r_xfer_idx == c_LAST_ADDR);

    // The RAM read register doubles as the prefetch slot: a new read is issued
    // only when that slot is empty or is being drained into the output stage,
    // so a stalled sample simply stays parked in the RAM output register.
    assign w_rd_issue = w_rd_start ||
                        ((r_state == c_ST_READ) && !r_rd_all && (!r_q_vld || w_out_adv));
    assign w_rd_addr  = w_rd_start ? '0 : r_rd_addr;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= {real_i, imag_i};
        end
        if (w_rd_issue) begin
            r_ram_q <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q_vld    <= 1'b0;
            valid_o    <= 1'b0;
            real_o     <= 8'd0;
            imag_o     <= 8'd0;
            r_xfer_idx <= '0;
        end else begin
            if (w_rd_issue) begin
                r_q_vld <= 1'b1;
            end else if (r_q_vld && w_out_adv) begin
                r_q_vld <= 1'b0;
            end

            if (w_out_adv) begin
                valid_o <= r_q_vld;
                if (r_q_vld) begin
                    real_o <= r_ram_q[15:8];
                    imag_o <= r_ram_q[7:0];
                end
            end

            if (w_rd_start) begin
                r_xfer_idx <= '0;
            end else if (w_xfer) begin
                r_xfer_idx <= r_xfer_idx + c_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            r_rd_all  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (arm_i) begin
                        r_state   <= c_ST_CAPTURE;
                        r_wr_addr <= '0;
                        busy_o    <= 1'b1;
                    end
                end
                c_ST_CAPTURE: begin
                    if (valid_i) begin
                        r_wr_addr <= r_wr_addr + c_ONE;
                        if (r_wr_addr == c_LAST_ADDR) begin
                            r_state <= c_ST_FULL;
                            busy_o  <= 1'b0;
                            done_o  <= 1'b1;
                        end
                    end
                end
                c_ST_FULL: begin
                    if (rd_start_i) begin
                        r_state   <= c_ST_READ;
                        // Address 0 is fetched on this same edge.
                        r_rd_addr <= c_ONE;
                        r_rd_all  <= 1'b0;
                        busy_o    <= 1'b1;
                        done_o    <= 1'b0;
                    end
                end
                c_ST_READ: begin
                    if (w_rd_issue) begin
                        r_rd_addr <= r_rd_addr + c_ONE;
                        if (r_rd_addr == c_LAST_ADDR) begin
                            r_rd_all <= 1'b1;
                        end
                    end
                    if (w_last_xfer) begin
                        r_state <= c_ST_IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_iq_capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : tb_iq_capture_ram
// Description : Directed, table-driven self-checking bench for iq_capture_ram.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iq_capture_ram;

    localparam int c_AW    = 3;
    localparam int c_DEPTH = 1 << c_AW;
    localparam int c_NVEC  = 19;

    logic       clk;
    logic       rst;
    logic       arm_i;
    logic [7:0] real_i;
    logic [7:0] imag_i;
    logic       valid_i;
    logic       rd_start_i;
    logic       rd_ready_i;
    logic [7:0] real_o;
    logic [7:0] imag_o;
    logic       valid_o;
    logic       busy_o;
    logic       done_o;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_re [c_DEPTH];
    logic [7:0] exp_im [c_DEPTH];

    typedef struct {
        logic       arm;
        logic       vld;
        logic [7:0] re;
        logic [7:0] im;
        logic       rs;
        logic       rdy;
        logic       ev;
        logic       eb;
        logic       ed;
        logic [7:0] er;
        logic [7:0] ei;
    } vec_t;

    vec_t tbl [c_NVEC];

    iq_capture_ram #(.ADDR_W(c_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .arm_i      (arm_i),
        .real_i     (real_i),
        .imag_i     (imag_i),
        .valid_i    (valid_i),
        .rd_start_i (rd_start_i),
        .rd_ready_i (rd_ready_i),
        .real_o     (real_o),
        .imag_o     (imag_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic arm, input logic vld, input logic [7:0] re,
                                input logic [7:0] im, input logic rs, input logic rdy,
                                input logic ev, input logic eb, input logic ed,
                                input logic [7:0] er, input logic [7:0] ei);
        vec_t v;
        v.arm = arm; v.vld = vld; v.re = re; v.im = im; v.rs = rs; v.rdy = rdy;
        v.ev = ev; v.eb = eb; v.ed = ed; v.er = er; v.ei = ei;
        return v;
    endfunction

    task automatic capture_consec();
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        for (int n = 0; n < c_DEPTH; n++) begin
            valid_i = 1'b1;
            real_i  = exp_re[n];
            imag_i  = exp_im[n];
            tick();
        end
        valid_i = 1'b0;
        chk("cap_done_busy", {30'd0, done_o, busy_o}, 32'd2);
    endtask

    // Starts a readout and consumes stop_after samples, checking each transfer
    // against exp_re/exp_im and that stalled outputs stay put.
    task automatic readout(input bit bp, input int stop_after);
        int         got;
        int         cyc;
        bit         stall;
        logic [7:0] hr;
        logic [7:0] hi;
        got = 0;
        cyc = 0;
        rd_start_i = 1'b1;
        rd_ready_i = 1'b0;
        tick();
        rd_start_i = 1'b0;
        chk("rd_start_busy_done", {30'd0, busy_o, done_o}, 32'd2);
        while (got < stop_after && cyc < 200) begin
            rd_ready_i = bp ? (cyc % 3 == 0) : 1'b1;
            stall = valid_o && !rd_ready_i;
            hr = real_o;
            hi = imag_o;
            if (valid_o && rd_ready_i) begin
                chk($sformatf("rd_data%0d", got), {16'd0, real_o, imag_o},
                    {16'd0, exp_re[got], exp_im[got]});
                got++;
            end
            tick();
            cyc++;
            if (stall) begin
                chk("stall_hold", {15'd0, valid_o, real_o, imag_o}, {15'd0, 1'b1, hr, hi});
            end
        end
        rd_ready_i = 1'b0;
        chk("rd_count", 32'(got), 32'(stop_after));
    endtask

    initial begin
        rst = 1'b1; arm_i = 1'b0; real_i = 8'd0; imag_i = 8'd0;
        valid_i = 1'b0; rd_start_i = 1'b0; rd_ready_i = 1'b0;

        // Reset and idle: samples without arm must change nothing.
        valid_i = 1'b1; real_i = 8'h12; imag_i = 8'h34;
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_outputs", {13'd0, real_o, imag_o, valid_o, busy_o, done_o}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            valid_i = i[0];
            real_i  = 8'(i * 37);
            imag_i  = 8'(i * 11);
            tick();
            chk("idle_status", {29'd0, valid_o, busy_o, done_o}, 32'd0);
        end
        valid_i = 1'b0;

        // Basic capture + readout, stray controls mixed in.
        tbl[0] = mk(1, 1, 8'd99, 8'd99, 0, 0, 0, 1, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 8; i++) begin
            tbl[i] = mk(i == 3, 1, 8'(i - 1 - 4), 8'(-(i - 1)), i == 5, 0,
                        0, i < 8, i == 8, 8'd0, 8'd0);
        end
        tbl[9] = mk(1, 1, 8'h55, 8'h55, 1, 1, 0, 1, 0, 8'd0, 8'd0);
        for (int i = 10; i <= 17; i++) begin
            tbl[i] = mk(i == 12, i == 12, 8'h11, 8'h11, i == 12, 1,
                        1, 1, 0, 8'(i - 10 - 4), 8'(-(i - 10)));
        end
        tbl[18] = mk(0, 0, 8'd0, 8'd0, 0, 1, 0, 0, 0, 8'd0, 8'd0);

        for (int i = 0; i < c_NVEC; i++) begin
            arm_i      = tbl[i].arm;
            valid_i    = tbl[i].vld;
            real_i     = tbl[i].re;
            imag_i     = tbl[i].im;
            rd_start_i = tbl[i].rs;
            rd_ready_i = tbl[i].rdy;
            tick();
            chk($sformatf("vec%0d_status", i), {29'd0, valid_o, busy_o, done_o},
                {29'd0, tbl[i].ev, tbl[i].eb, tbl[i].ed});
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), {16'd0, real_o, imag_o},
                    {16'd0, tbl[i].er, tbl[i].ei});
            end
        end
        arm_i = 1'b0; valid_i = 1'b0; rd_start_i = 1'b0; rd_ready_i = 1'b0;

        // Gapped input with ignored controls, 9th sample dropped, backpressured readout.
        for (int n = 0; n < c_DEPTH; n++) begin
            exp_re[n] = n[0] ? 8'h80 : 8'h7F;
            exp_im[n] = 8'(n);
        end
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        chk("gap_busy", {31'd0, busy_o}, 32'd1);
        for (int n = 0; n < c_DEPTH; n++) begin
            for (int g = 0; g < 2; g++) begin
                arm_i      = (n == 2 && g == 0);
                rd_start_i = (n == 4 && g == 1);
                tick();
            end
            arm_i = 1'b0; rd_start_i = 1'b0;
            valid_i = 1'b1; real_i = exp_re[n]; imag_i = exp_im[n];
            tick();
            valid_i = 1'b0;
            chk($sformatf("gap_done%0d", n), {31'd0, done_o}, {31'd0, n == c_DEPTH - 1});
        end
        valid_i = 1'b1; real_i = 8'h33; imag_i = 8'h33; arm_i = 1'b1;
        tick();
        valid_i = 1'b0; arm_i = 1'b0;
        chk("full_ignores", {30'd0, busy_o, done_o}, 32'd1);
        readout(1'b1, c_DEPTH);
        chk("bp_end_status", {29'd0, valid_o, busy_o, done_o}, 32'd0);
        rd_ready_i = 1'b1;
        tick();
        chk("bp_no_extra", {31'd0, valid_o}, 32'd0);
        rd_ready_i = 1'b0;

        // Re-arm on first idle cycle, reset mid-readout, then a clean run.
        for (int n = 0; n < c_DEPTH; n++) begin
            exp_re[n] = 8'(n * 16 + 1);
            exp_im[n] = ~8'(n);
        end
        capture_consec();
        readout(1'b0, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_reset", {13'd0, real_o, imag_o, valid_o, busy_o, done_o}, 32'd0);
        for (int n = 0; n < c_DEPTH; n++) begin
            exp_re[n] = 8'(-n - 1);
            exp_im[n] = 8'(n * 9 + 5);
        end
        capture_consec();
        readout(1'b1, c_DEPTH);
        chk("final_status", {29'd0, valid_o, busy_o, done_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
